// File: rtl/audio_out_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_scheduler_if
// Description : Bundle of the signals between the audio output scheduler, its
//               two sample sources and the audio controller write port.
//               master : the scheduler (drives ready, audio data, strobe and
//                        status counters)
//               slave  : the environment (drives mode, source samples/valids
//                        and the controller's audio_out_allowed)
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_out_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            mode;
    logic                  src0_valid;
    logic                  src1_valid;
    logic [DATA_WIDTH-1:0] src0_left;
    logic [DATA_WIDTH-1:0] src0_right;
    logic [DATA_WIDTH-1:0] src1_left;
    logic [DATA_WIDTH-1:0] src1_right;
    logic                  src0_ready;
    logic                  src1_ready;
    logic                  audio_out_allowed;
    logic [DATA_WIDTH-1:0] left_channel_audio_out;
    logic [DATA_WIDTH-1:0] right_channel_audio_out;
    logic                  write_audio_out;
    logic [15:0]           underrun_count;
    logic [15:0]           drop_count;

    modport master (
        input  mode, src0_valid, src1_valid,
        input  src0_left, src0_right, src1_left, src1_right,
        input  audio_out_allowed,
        output src0_ready, src1_ready,
        output left_channel_audio_out, right_channel_audio_out,
        output write_audio_out, underrun_count, drop_count
    );

    modport slave (
        output mode, src0_valid, src1_valid,
        output src0_left, src0_right, src1_left, src1_right,
        output audio_out_allowed,
        input  src0_ready, src1_ready,
        input  left_channel_audio_out, right_channel_audio_out,
        input  write_audio_out, underrun_count, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/audio_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_scheduler
// Description : Paces stereo sample delivery to the audio controller at one
//               sample every SAMPLE_DIV clocks. Each period it pulls one pair
//               from the selected source(s), selects / saturating-mixes /
//               mutes, and issues a one-cycle write when the controller FIFO
//               has room. Missing samples and lost periods are counted.
// Ports       : CLOCK_50 - system clock, rising edge
//               reset    - asynchronous, active-low reset
//               bus      - audio_out_scheduler_if.master (sources, controller
//                          write port, status counters)
// Revision    : 1.0 - initial release
// ============================================================================
module audio_out_scheduler #(
    parameter int SAMPLE_DIV = 1042,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic              CLOCK_50,
    input  wire logic              reset,
    audio_out_scheduler_if.master  bus
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [15:0]      c_cnt_max   = 16'hFFFF;

    localparam logic [1:0] c_mode_src0 = 2'b00;
    localparam logic [1:0] c_mode_src1 = 2'b01;
    localparam logic [1:0] c_mode_mix  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_tick_cnt;
    logic [1:0]            r_mode;

    logic                  w_tick;
    logic                  w_sel0;
    logic                  w_sel1;
    logic                  w_underrun;
    logic [DATA_WIDTH-1:0] w_s0_l, w_s0_r, w_s1_l, w_s1_r;
    logic [DATA_WIDTH-1:0] w_next_l, w_next_r;

    // Signed add clamped to the representable range: overflow shows up as the
    // two top bits of the one-bit-wider sum disagreeing.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            sat_add = s[DATA_WIDTH-1:0];
    endfunction

    assign w_tick = (r_tick_cnt == c_tick_last);

    // Selection uses the mode latched on the tick edge, so ready in FETCH is
    // consistent with the data path that captures at the end of FETCH.
    assign w_sel0 = (r_mode == c_mode_src0) || (r_mode == c_mode_mix);
    assign w_sel1 = (r_mode == c_mode_src1) || (r_mode == c_mode_mix);

    assign bus.src0_ready = (r_state == ST_FETCH) && w_sel0;
    assign bus.src1_ready = (r_state == ST_FETCH) && w_sel1;

    // A source without a sample contributes silence.
    assign w_s0_l = bus.src0_valid ? bus.src0_left  : '0;
    assign w_s0_r = bus.src0_valid ? bus.src0_right : '0;
    assign w_s1_l = bus.src1_valid ? bus.src1_left  : '0;
    assign w_s1_r = bus.src1_valid ? bus.src1_right : '0;

    // One underrun per period regardless of how many selected sources miss.
    assign w_underrun = (w_sel0 && !bus.src0_valid) || (w_sel1 && !bus.src1_valid);

    always_comb begin
        w_next_l = '0;
        w_next_r = '0;
        case (r_mode)
            c_mode_src0: begin
                w_next_l = w_s0_l;
                w_next_r = w_s0_r;
            end
            c_mode_src1: begin
                w_next_l = w_s1_l;
                w_next_r = w_s1_r;
            end
            c_mode_mix: begin
                w_next_l = sat_add(w_s0_l, w_s1_l);
                w_next_r = sat_add(w_s0_r, w_s1_r);
            end
            default: begin
                w_next_l = '0;
                w_next_r = '0;
            end
        endcase
    end

    // Free-running period counter; its rate does not depend on the FSM.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state                     <= ST_IDLE;
            r_mode                      <= 2'b00;
            bus.left_channel_audio_out  <= '0;
            bus.right_channel_audio_out <= '0;
            bus.write_audio_out         <= 1'b0;
            bus.underrun_count          <= '0;
            bus.drop_count              <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus.write_audio_out <= 1'b0;
                    if (w_tick) begin
                        r_state <= ST_FETCH;
                        r_mode  <= bus.mode;
                    end
                end
                ST_FETCH: begin
                    r_state                     <= ST_WRITE;
                    bus.left_channel_audio_out  <= w_next_l;
                    bus.right_channel_audio_out <= w_next_r;
                    // Strobe is high during WRITE only if the FIFO had room.
                    bus.write_audio_out         <= bus.audio_out_allowed;
                    if (w_underrun && (bus.underrun_count != c_cnt_max))
                        bus.underrun_count <= bus.underrun_count + 16'd1;
                    if (!bus.audio_out_allowed && (bus.drop_count != c_cnt_max))
                        bus.drop_count <= bus.drop_count + 16'd1;
                end
                ST_WRITE: begin
                    r_state             <= ST_IDLE;
                    bus.write_audio_out <= 1'b0;
                end
                default: begin
                    r_state             <= ST_IDLE;
                    bus.write_audio_out <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
